// File: rtl/floor_display_ctrl.sv
// Elevator floor/direction indicator for the DE1-SoC HEX displays: one-hot floor decode,
// blinking travel direction, arrival flash, door glyph and invalid-floor reporting.
module floor_display_ctrl #(
    parameter int                    NUM_FLOORS     = 6,
    parameter logic [NUM_FLOORS-1:0] MEZZ_MASK      = 6'b010100,
    parameter int                    BLINK_DIV      = 25000000,
    parameter int                    ARRIVE_FLASHES = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] currentFloor,
    input  logic                  Up,
    input  logic                  Down,
    input  logic                  moving,
    input  logic                  door_open,
    output logic [6:0]            HEX0,
    output logic [6:0]            HEX2,
    output logic [6:0]            HEX3,
    output logic [6:0]            HEX4,
    output logic                  floor_err
);

    localparam int DIV_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam int FL_W  = $clog2(2 * ARRIVE_FLASHES + 2);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_O     = 7'b0100011;
    localparam logic [6:0] SEG_M     = 7'b1001000;

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // A floor's label counts the non-mezzanine floors up to and including it.
    function automatic int label_of(input int idx);
        int n;
        n = 0;
        for (int b = 0; b < NUM_FLOORS; b++)
            if (b <= idx && !MEZZ_MASK[b]) n++;
        return n;
    endfunction

    if (label_of(NUM_FLOORS - 1) > 9) begin : g_label_range
        $error("floor_display_ctrl: floor labels exceed a single digit");
    end
    if (BLINK_DIV < 2) begin : g_div_range
        $error("floor_display_ctrl: BLINK_DIV must be at least 2");
    end
    if (MEZZ_MASK[0]) begin : g_mezz_range
        $error("floor_display_ctrl: the lowest floor cannot be a mezzanine");
    end

    logic [DIV_W-1:0]      div_q, div_d;
    logic                  phase_q, phase_d;
    logic [FL_W-1:0]       flash_q, flash_d;
    logic [NUM_FLOORS-1:0] last_valid_q, last_valid_d;
    logic                  moving_q;
    logic [6:0]            hex0_q, hex0_d, hex2_q, hex2_d, hex3_q, hex3_d, hex4_q, hex4_d;
    logic                  err_q, err_d;

    logic       valid, tick, arrive, mezz, blank_label;
    logic [6:0] label_seg, dir_seg;

    always_comb begin
        valid  = $onehot(currentFloor);
        tick   = (div_q == DIV_W'(BLINK_DIV - 1));
        arrive = moving_q && !moving && valid;

        div_d   = tick ? '0 : div_q + DIV_W'(1);
        phase_d = tick ? ~phase_q : phase_q;
        flash_d = flash_q;
        if (tick && flash_q != '0)
            flash_d = flash_q - FL_W'(1);
        if (!valid || (moving && !moving_q))
            flash_d = '0;
        // Arrival restarts the blink timebase so the flash begins with a full dark phase.
        if (arrive) begin
            div_d   = '0;
            phase_d = 1'b0;
            flash_d = FL_W'(2 * ARRIVE_FLASHES);
        end
        last_valid_d = valid ? currentFloor : last_valid_q;

        label_seg = SEG_BLANK;
        mezz      = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (last_valid_d[i]) begin
                label_seg = digit_seg(label_of(i));
                mezz      = MEZZ_MASK[i];
            end
        end
        blank_label = (flash_d != '0) && !phase_d;

        case ({Up, Down})
            2'b10:   dir_seg = SEG_U;
            2'b01:   dir_seg = SEG_D;
            2'b11:   dir_seg = SEG_DASH;
            default: dir_seg = SEG_BLANK;
        endcase

        if (!valid) begin
            err_d  = 1'b1;
            hex4_d = SEG_E;
            hex3_d = SEG_BLANK;
            hex2_d = SEG_BLANK;
            hex0_d = SEG_DASH;
        end else begin
            err_d  = 1'b0;
            hex4_d = blank_label ? SEG_BLANK : label_seg;
            hex3_d = (blank_label || !mezz) ? SEG_BLANK : SEG_M;
            hex2_d = hex3_d;
            if (moving)
                hex0_d = phase_d ? dir_seg : SEG_BLANK;
            else if (door_open)
                hex0_d = SEG_O;
            else
                hex0_d = dir_seg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q        <= '0;
            phase_q      <= 1'b1;
            flash_q      <= '0;
            last_valid_q <= '0;
            moving_q     <= 1'b0;
            hex0_q       <= SEG_BLANK;
            hex2_q       <= SEG_BLANK;
            hex3_q       <= SEG_BLANK;
            hex4_q       <= SEG_BLANK;
            err_q        <= 1'b0;
        end else begin
            div_q        <= div_d;
            phase_q      <= phase_d;
            flash_q      <= flash_d;
            last_valid_q <= last_valid_d;
            moving_q     <= moving;
            hex0_q       <= hex0_d;
            hex2_q       <= hex2_d;
            hex3_q       <= hex3_d;
            hex4_q       <= hex4_d;
            err_q        <= err_d;
        end
    end

    assign HEX0      = hex0_q;
    assign HEX2      = hex2_q;
    assign HEX3      = hex3_q;
    assign HEX4      = hex4_q;
    assign floor_err = err_q;

endmodule

// File: tb/tb_floor_display_ctrl.sv
// Bench for floor_display_ctrl: fixed vectors, hand-written flash/reset sequences,
// and random stimulus against a timeline-based reference model.
module tb_floor_display_ctrl;

    localparam int NF = 6;
    localparam logic [NF-1:0] MASK = 6'b010100;
    localparam int BD = 4;
    localparam int AF = 3;

    localparam logic [6:0] BL   = 7'b1111111;
    localparam logic [6:0] S_U  = 7'b1000001;
    localparam logic [6:0] S_D  = 7'b0100001;
    localparam logic [6:0] S_E  = 7'b0000110;
    localparam logic [6:0] S_DA = 7'b0111111;
    localparam logic [6:0] S_O  = 7'b0100011;
    localparam logic [6:0] S_M  = 7'b1001000;

    logic [6:0] digits [10];

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NF-1:0] cf = '0;
    logic          up = 1'b0, dn = 1'b0, mv = 1'b0, door = 1'b0;
    logic [6:0]    hex0, hex2, hex3, hex4;
    logic          ferr;

    int n_cmp = 0;
    int n_bad = 0;

    floor_display_ctrl #(
        .NUM_FLOORS(NF), .MEZZ_MASK(MASK), .BLINK_DIV(BD), .ARRIVE_FLASHES(AF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .currentFloor(cf), .Up(up), .Down(dn),
        .moving(mv), .door_open(door), .HEX0(hex0), .HEX2(hex2), .HEX3(hex3),
        .HEX4(hex4), .floor_err(ferr)
    );

    always #5 clk = ~clk;

    // Reference model: tracks cycles elapsed since the last timebase restart
    // (reset or arrival) and derives blink phase and flash state from that.
    int         m_age;
    bit         m_ref_ph, m_flash_on, m_mov;
    logic [6:0] e0, e2, e3, e4;
    logic       eerr;

    function automatic int label_for(input int idx);
        int n;
        n = 0;
        for (int b = 0; b <= idx; b++)
            if (MASK[b] == 1'b0) n++;
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_age = 0; m_ref_ph = 1'b1; m_flash_on = 1'b0; m_mov = 1'b0;
            e0 = BL; e2 = BL; e3 = BL; e4 = BL; eerr = 1'b0;
        end else begin
            bit valid, ph, fl_act, blank;
            int idx;
            logic [6:0] dir;
            valid = ($countones(cf) == 1);
            if (valid && m_mov && !mv) begin
                m_age = 0; m_ref_ph = 1'b0; m_flash_on = 1'b1;
            end else begin
                m_age++;
            end
            if (!valid || (mv && !m_mov)) m_flash_on = 1'b0;
            ph     = m_ref_ph ^ (((m_age / BD) % 2) == 1);
            fl_act = m_flash_on && ((m_age / BD) < 2 * AF);
            m_mov  = mv;
            if (up && !dn)      dir = S_U;
            else if (dn && !up) dir = S_D;
            else if (up && dn)  dir = S_DA;
            else                dir = BL;
            if (!valid) begin
                eerr = 1'b1; e4 = S_E; e3 = BL; e2 = BL; e0 = S_DA;
            end else begin
                idx = 0;
                for (int i = 0; i < NF; i++) if (cf[i]) idx = i;
                blank = fl_act && !ph;
                eerr = 1'b0;
                e4 = blank ? BL : digits[label_for(idx)];
                e3 = (blank || !MASK[idx]) ? BL : S_M;
                e2 = e3;
                if (mv)        e0 = ph ? dir : BL;
                else if (door) e0 = S_O;
                else           e0 = dir;
            end
        end
    end

    task automatic check7(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string name);
        check7({name, ".HEX0"}, hex0, e0);
        check7({name, ".HEX2"}, hex2, e2);
        check7({name, ".HEX3"}, hex3, e3);
        check7({name, ".HEX4"}, hex4, e4);
        check7({name, ".err"}, {6'b0, ferr}, {6'b0, eerr});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [NF-1:0] fl;
        logic up, dn, door;
        logic [6:0] e4, e3, e0;
        logic eerr;
    } vec_t;

    vec_t vecs [10];

    task automatic flash_label_check(input string name, input int k,
                                     input logic [6:0] dig, input bit is_mezz);
        bit dark;
        dark = (k < 2 * AF * BD) && (((k / BD) % 2) == 0);
        check7({name, ".HEX4"}, hex4, dark ? BL : dig);
        check7({name, ".HEX3"}, hex3, (dark || !is_mezz) ? BL : S_M);
        check7({name, ".HEX2"}, hex2, (dark || !is_mezz) ? BL : S_M);
    endtask

    initial begin
        digits = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        vecs[0] = '{6'b000001, 1, 0, 0, 7'b1111001, BL,  S_U,  0};
        vecs[1] = '{6'b000010, 0, 1, 0, 7'b0100100, BL,  S_D,  0};
        vecs[2] = '{6'b000100, 1, 1, 0, 7'b0100100, S_M, S_DA, 0};
        vecs[3] = '{6'b001000, 0, 0, 0, 7'b0110000, BL,  BL,   0};
        vecs[4] = '{6'b010000, 1, 0, 1, 7'b0110000, S_M, S_O,  0};
        vecs[5] = '{6'b100000, 1, 0, 0, 7'b0011001, BL,  S_U,  0};
        vecs[6] = '{6'b000011, 1, 0, 0, S_E,        BL,  S_DA, 1};
        vecs[7] = '{6'b000000, 1, 0, 0, S_E,        BL,  S_DA, 1};
        vecs[8] = '{6'b001000, 1, 0, 0, 7'b0110000, BL,  S_U,  0};
        vecs[9] = '{6'b001000, 0, 1, 1, 7'b0110000, BL,  S_O,  0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check7("rst.HEX0", hex0, BL);
        check7("rst.HEX2", hex2, BL);
        check7("rst.HEX3", hex3, BL);
        check7("rst.HEX4", hex4, BL);
        check7("rst.err", {6'b0, ferr}, 7'd0);
        @(negedge clk) reset_n = 1'b1;

        // Fixed vectors, car stationary
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            cf = vecs[v].fl; up = vecs[v].up; dn = vecs[v].dn; door = vecs[v].door; mv = 1'b0;
            step();
            check7($sformatf("vec%0d.HEX4", v), hex4, vecs[v].e4);
            check7($sformatf("vec%0d.HEX3", v), hex3, vecs[v].e3);
            check7($sformatf("vec%0d.HEX2", v), hex2, vecs[v].e3);
            check7($sformatf("vec%0d.HEX0", v), hex0, vecs[v].e0);
            check7($sformatf("vec%0d.err", v), {6'b0, ferr}, {6'b0, vecs[v].eerr});
        end

        // Blinking direction while moving, door open must not override it
        @(negedge clk);
        cf = 6'b000001; up = 1'b1; dn = 1'b0; door = 1'b1; mv = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            check_model("blink_up");
            if (k == 5) begin
                @(negedge clk);
                up = 1'b0; dn = 1'b1;
            end
        end

        // Arrival flash at floor 2M
        @(negedge clk);
        cf = 6'b000100; door = 1'b0;
        step();
        @(negedge clk) mv = 1'b0;
        for (int k = 0; k < 28; k++) begin
            step();
            flash_label_check("arrive", k, digits[2], 1'b1);
        end

        // Moving rises mid-flash: label goes steady on the next cycle
        @(negedge clk) mv = 1'b1;
        step();
        @(negedge clk) mv = 1'b0;
        step();
        flash_label_check("cancel_pre", 0, digits[2], 1'b1);
        @(negedge clk) mv = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check7("cancel.HEX4", hex4, digits[2]);
            check7("cancel.HEX3", hex3, S_M);
        end

        // Error during a flash clears it
        @(negedge clk) mv = 1'b0;
        step();
        @(negedge clk) cf = 6'b000011;
        step();
        check7("errflash.HEX4", hex4, S_E);
        @(negedge clk) cf = 6'b000100;
        step();
        check7("errflash.after", hex4, digits[2]);

        // Asynchronous reset mid-blink
        @(negedge clk) mv = 1'b1; up = 1'b1; dn = 1'b0;
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        check7("areset.HEX0", hex0, BL);
        check7("areset.HEX4", hex4, BL);
        check7("areset.HEX3", hex3, BL);
        check7("areset.err", {6'b0, ferr}, 7'd0);
        @(negedge clk) reset_n = 1'b1;

        // Random stimulus against the reference model
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) cf = NF'($urandom);
            else if ($urandom_range(0, 3) == 0) cf = NF'(1) << $urandom_range(0, NF - 1);
            if ($urandom_range(0, 5) == 0) mv = ~mv;
            up   = 1'($urandom);
            dn   = 1'($urandom);
            door = 1'($urandom);
            step();
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
